if_fetch_stage: RTL and testbench

Instruction-fetch front end of the 5-stage pipelined CPU: owns the program counter, drives the synchronous instruction memory, and presents the fetched instruction plus PC+1 to the decode stage (control, regfile, ID/EXE register). It supports decode-stage stalls, and flushes with a redirect from the branch resolution logic in EXE. It is word-addressed: sequential PC increments by 1.

---
 rtl/if_fetch_stage_if.sv | 29 ++
 rtl/if_fetch_stage.sv | 68 ++++++
 tb/tb_if_fetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: bus between the fetch stage, the instruction memory and decode.
//   stall, flush, redirect_pc : pipeline control into fetch
//   imem_addr / imem_rdata    : synchronous instruction memory (1-cycle read latency)
//   inst_IF_ID, npc_IF_ID,
//   valid_IF_ID               : IF/ID slot presented to decode
// master = fetch stage, slave = its environment (memory + control + decode).
interface if_fetch_stage_if #(
    parameter int ISIZE = 32,
    parameter int DSIZE = 32
);
    logic             stall;
    logic             flush;
    logic [ISIZE-1:0] redirect_pc;
    logic [ISIZE-1:0] imem_addr;
    logic [DSIZE-1:0] imem_rdata;
    logic [DSIZE-1:0] inst_IF_ID;
    logic [ISIZE-1:0] npc_IF_ID;
    logic             valid_IF_ID;

    modport master (
        input  stall, flush, redirect_pc, imem_rdata,
        output imem_addr, inst_IF_ID, npc_IF_ID, valid_IF_ID
    );

    modport slave (
        output stall, flush, redirect_pc, imem_rdata,
        input  imem_addr, inst_IF_ID, npc_IF_ID, valid_IF_ID
    );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch front end. Owns the PC, drives a synchronous
// instruction memory and presents instruction + PC+1 to decode. Word addressed.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   bus          if_fetch_stage_if.master (stall/flush/redirect, imem, IF/ID slot)
//   fetch_cnt    (IF_PERF_CNT_EN only) instructions accepted by decode, saturating
//   bubble_cnt   (IF_PERF_CNT_EN only) cycles with an empty IF/ID slot, saturating
// Build option: define IF_PERF_CNT_EN to add the two performance counters.
module if_fetch_stage #(
    parameter int               ISIZE    = 32,
    parameter int               DSIZE    = 32,
    parameter logic [ISIZE-1:0] RESET_PC = '0,
    parameter logic [DSIZE-1:0] NOP_INST = '0
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]              fetch_cnt,
    output logic [31:0]              bubble_cnt,
`endif
    if_fetch_stage_if.master         bus
);

    logic [ISIZE-1:0] pc_q;     // next address to fetch
    logic [ISIZE-1:0] id_pc_q;  // address whose data is on imem_rdata now
    logic             id_vld_q; // IF/ID slot full

    // A stall re-reads the word already in the slot, so the memory output
    // itself holds the instruction and no skid buffer is needed.
    assign bus.imem_addr   = (bus.stall && !bus.flush) ? id_pc_q : pc_q;
    assign bus.inst_IF_ID  = id_vld_q ? bus.imem_rdata : NOP_INST;
    assign bus.npc_IF_ID   = id_pc_q + ISIZE'(1);
    assign bus.valid_IF_ID = id_vld_q;

    // Flush beats stall; stall freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            id_pc_q  <= RESET_PC;
            id_vld_q <= 1'b0;
        end else if (bus.flush) begin
            pc_q     <= bus.redirect_pc;
            id_vld_q <= 1'b0;
        end else if (!bus.stall) begin
            id_pc_q  <= pc_q;
            pc_q     <= pc_q + ISIZE'(1);
            id_vld_q <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Out of reset, every edge with an empty slot is a bubble; an accepted
    // instruction is a full slot that decode does not stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (id_vld_q && !bus.stall && fetch_cnt != '1)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (!id_vld_q && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_w = 1'b0;
    always #5 clk = ~clk;

    // main DUT: 32-bit addresses, RESET_PC=0
    if_fetch_stage_if #(.ISIZE(32), .DSIZE(32)) bus ();
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif
    if_fetch_stage #(.ISIZE(32), .DSIZE(32), .RESET_PC(32'd0), .NOP_INST(32'h0)) dut (
        .clk(clk),
        .rst(rst),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt(fetch_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .bus(bus)
    );

    // wrap DUT: 4-bit addresses, RESET_PC=14
    if_fetch_stage_if #(.ISIZE(4), .DSIZE(32)) bus_w ();
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_w, bubble_cnt_w;
`endif
    if_fetch_stage #(.ISIZE(4), .DSIZE(32), .RESET_PC(4'd14), .NOP_INST(32'h0)) dut_w (
        .clk(clk),
        .rst(rst_w),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt(fetch_cnt_w),
        .bubble_cnt(bubble_cnt_w),
`endif
        .bus(bus_w)
    );

    // memory model: mem[a] = 32'h1000_0000 + a, 1-cycle read latency
    always @(posedge clk) begin
        bus.imem_rdata   <= 32'h1000_0000 + bus.imem_addr;
        bus_w.imem_rdata <= 32'h1000_0000 + 32'(bus_w.imem_addr);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic vld, input logic [31:0] inst,
                              input logic [31:0] npc, input logic [31:0] addr);
        check({tag, " valid"}, 32'(bus.valid_IF_ID), 32'(vld));
        check({tag, " inst"},  bus.inst_IF_ID, inst);
        check({tag, " npc"},   bus.npc_IF_ID, npc);
        check({tag, " addr"},  bus.imem_addr, addr);
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic        vld;
        logic [31:0] inst;
        logic [31:0] npc;
        logic [31:0] addr;
    } vec_t;

    function automatic vec_t mk(logic s, logic f, logic [31:0] r, logic v,
                                logic [31:0] i, logic [31:0] n, logic [31:0] a);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.vld = v;
        t.inst = i; t.npc = n; t.addr = a;
        return t;
    endfunction

    vec_t tbl[23];

    initial begin
        // inputs applied during the cycle; expected outputs in that same cycle
        tbl[0]  = mk(0, 0,   0, 0, 32'h0,         1,   0);
        tbl[1]  = mk(0, 0,   0, 1, 32'h1000_0000, 1,   1);
        tbl[2]  = mk(0, 0,   0, 1, 32'h1000_0001, 2,   2);
        tbl[3]  = mk(0, 0,   0, 1, 32'h1000_0002, 3,   3);
        tbl[4]  = mk(0, 0,   0, 1, 32'h1000_0003, 4,   4);
        tbl[5]  = mk(0, 0,   0, 1, 32'h1000_0004, 5,   5);
        tbl[6]  = mk(1, 0,   0, 1, 32'h1000_0005, 6,   5);   // stall x3
        tbl[7]  = mk(1, 0,   0, 1, 32'h1000_0005, 6,   5);
        tbl[8]  = mk(1, 0,   0, 1, 32'h1000_0005, 6,   5);
        tbl[9]  = mk(0, 0,   0, 1, 32'h1000_0005, 6,   6);   // held data cycle
        tbl[10] = mk(0, 0,   0, 1, 32'h1000_0006, 7,   7);
        tbl[11] = mk(0, 1,  20, 1, 32'h1000_0007, 8,   8);   // flush -> 20
        tbl[12] = mk(0, 0,   0, 0, 32'h0,         8,  20);
        tbl[13] = mk(0, 0,   0, 1, 32'h1000_0014, 21, 21);
        tbl[14] = mk(1, 1,  40, 1, 32'h1000_0015, 22, 22);  // flush+stall
        tbl[15] = mk(0, 0,   0, 0, 32'h0,         22, 40);
        tbl[16] = mk(0, 0,   0, 1, 32'h1000_0028, 41, 41);
        tbl[17] = mk(0, 1,  42, 1, 32'h1000_0029, 42, 42);  // redirect to own pc
        tbl[18] = mk(0, 0,   0, 0, 32'h0,         42, 42);
        tbl[19] = mk(0, 1, 100, 1, 32'h1000_002A, 43, 43);
        tbl[20] = mk(1, 0,   0, 0, 32'h0,         43, 42);  // stall while empty
        tbl[21] = mk(0, 0,   0, 0, 32'h0,         43, 100);
        tbl[22] = mk(0, 0,   0, 1, 32'h1000_0064, 101, 101);

        bus.stall = 0; bus.flush = 0; bus.redirect_pc = '0;
        bus_w.stall = 0; bus_w.flush = 0; bus_w.redirect_pc = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_main("reset", 0, 32'h0, 1, 0);
`ifdef IF_PERF_CNT_EN
        check("reset fetch_cnt", fetch_cnt, 0);
        check("reset bubble_cnt", bubble_cnt, 0);
`endif
        rst = 1;

        for (int i = 0; i < 23; i++) begin
            bus.stall = tbl[i].stall;
            bus.flush = tbl[i].flush;
            bus.redirect_pc = tbl[i].redir;
            #1;
            check_main($sformatf("vec%0d", i), tbl[i].vld, tbl[i].inst, tbl[i].npc, tbl[i].addr);
            @(posedge clk);
            @(negedge clk);
        end
        bus.stall = 0; bus.flush = 0;

        // mid-run reset: outputs and counters return to reset values at once
        #2;
        rst = 0;
        #1;
        check_main("midrst", 0, 32'h0, 1, 0);
`ifdef IF_PERF_CNT_EN
        check("midrst fetch_cnt", fetch_cnt, 0);
        check("midrst bubble_cnt", bubble_cnt, 0);
`endif
        @(negedge clk);
        rst = 1;

        // 1 post-reset bubble, 10 valid cycles (2 stalled, last one flushed), 1 flush bubble
        for (int j = 0; j < 12; j++) begin
            bus.stall = (j == 3 || j == 4);
            bus.flush = (j == 10);
            bus.redirect_pc = 32'd0;
            #1;
            if (j == 1) check("perf seq inst c1", bus.inst_IF_ID, 32'h1000_0000);
            if (j == 11) check("perf seq valid c11", 32'(bus.valid_IF_ID), 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.stall = 0; bus.flush = 0;
        #1;
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 8);
        check("bubble_cnt", bubble_cnt, 2);
`endif
        check("perf seq inst c12", bus.inst_IF_ID, 32'h1000_0000);

        // PC wrap with ISIZE=4, RESET_PC=14
        @(negedge clk);
        rst_w = 1;
        #1;
        check("wrap c0 valid", 32'(bus_w.valid_IF_ID), 0);
        check("wrap c0 addr", 32'(bus_w.imem_addr), 14);
        @(negedge clk); #1;
        check("wrap c1 inst", bus_w.inst_IF_ID, 32'h1000_000E);
        check("wrap c1 npc", 32'(bus_w.npc_IF_ID), 15);
        @(negedge clk); #1;
        check("wrap c2 inst", bus_w.inst_IF_ID, 32'h1000_000F);
        check("wrap c2 npc", 32'(bus_w.npc_IF_ID), 0);
        check("wrap c2 addr", 32'(bus_w.imem_addr), 0);
        @(negedge clk); #1;
        check("wrap c3 inst", bus_w.inst_IF_ID, 32'h1000_0000);
        check("wrap c3 npc", 32'(bus_w.npc_IF_ID), 1);
        @(negedge clk); #1;
        check("wrap c4 inst", bus_w.inst_IF_ID, 32'h1000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected done");
        $fatal(1, "timeout");
    end

endmodule
